// File: rtl/sim_run_ctrl.sv
// Run controller for the simulation top. It holds the DUT in reset for a
// fixed number of cycles and then lets it run. The run ends on the DUT's
// done or fail indication, or when the cycle limit is reached. After a
// drain window it raises finish_req, which the top uses to end the run.
//
// state | meaning
// ------+---------------------------------------------------------------
// HOLD  | DUT held in reset, hold counter running
// RUN   | DUT running, cycles counted, done/fail/timeout watched
// DRAIN | run over, outcome latched, waiting DRAIN_CYCLES before finish
// DONE  | finish requested; terminal until reset
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             dut_done_i,
    input  logic             dut_fail_i,
    output logic             dut_reset_o,
    output logic             running_o,
    output logic             finish_req_o,
    output logic             finish_pulse_o,
    output logic [1:0]       status_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // Counters are sized to their own terminal value; keep at least one bit
    // so a zero drain window or single hold cycle still elaborates.
    localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0]   MAX_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT    = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [1:0]         status_q, status_d;
    logic               dut_reset_q, dut_reset_d;
    logic               running_q, running_d;
    logic               finish_req_q, finish_req_d;
    logic               finish_pulse_q, finish_pulse_d;
    logic               run_exit;

    // State and output registers; reset overrides everything.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= HOLD;
            hold_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            cycle_cnt_q    <= '0;
            status_q       <= ST_NONE;
            dut_reset_q    <= 1'b1;
            running_q      <= 1'b0;
            finish_req_q   <= 1'b0;
            finish_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            cycle_cnt_q    <= cycle_cnt_d;
            status_q       <= status_d;
            dut_reset_q    <= dut_reset_d;
            running_q      <= running_d;
            finish_req_q   <= finish_req_d;
            finish_pulse_q <= finish_pulse_d;
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        cycle_cnt_d    = cycle_cnt_q;
        status_d       = status_q;
        dut_reset_d    = dut_reset_q;
        running_d      = running_q;
        finish_req_d   = finish_req_q;
        finish_pulse_d = 1'b0;
        run_exit       = 1'b0;

        case (state_q)
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = RUN;
                    dut_reset_d = 1'b0;
                    running_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            RUN: begin
                if (cycle_cnt_q != CNT_SAT) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                // fail beats done, and either beats a timeout on the same edge
                if (dut_fail_i) begin
                    run_exit = 1'b1;
                    status_d = ST_FAIL;
                end else if (dut_done_i) begin
                    run_exit = 1'b1;
                    status_d = ST_PASS;
                end else if (cycle_cnt_q == MAX_LAST) begin
                    run_exit = 1'b1;
                    status_d = ST_TIMEOUT;
                end
                if (run_exit) begin
                    running_d = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d        = DONE;
                        finish_req_d   = 1'b1;
                        finish_pulse_d = 1'b1;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end

            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d        = DONE;
                    finish_req_d   = 1'b1;
                    finish_pulse_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end

            DONE: begin
                finish_req_d = 1'b1;
            end

            default: begin
                state_d = HOLD;
            end
        endcase
    end

    assign dut_reset_o    = dut_reset_q;
    assign running_o      = running_q;
    assign finish_req_o   = finish_req_q;
    assign finish_pulse_o = finish_pulse_q;
    assign status_o       = status_q;
    assign cycle_count_o  = cycle_cnt_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: expected outcomes are queued when done/fail is
// driven (or when a timeout run starts) and checked when finish_pulse fires.
module tb_sim_run_ctrl;

    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned MAX_CYCLES   = 20;
    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned CNT_W        = 16;

    logic             clock;
    logic             reset;
    logic             dut_done;
    logic             dut_fail;
    logic             dut_reset;
    logic             running;
    logic             finish_req;
    logic             finish_pulse;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_count;

    typedef struct packed {
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   pulse_cnt = 0;

    sim_run_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .dut_done_i     (dut_done),
        .dut_fail_i     (dut_fail),
        .dut_reset_o    (dut_reset),
        .running_o      (running),
        .finish_req_o   (finish_req),
        .finish_pulse_o (finish_pulse),
        .status_o       (status),
        .cycle_count_o  (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // count every finish pulse, sampled just after the edge
    always @(posedge clock) begin
        #1;
        if (finish_pulse) pulse_cnt = pulse_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Assert reset for n cycles, release it and check the HOLD -> RUN sequence.
    task automatic reset_seq(input int n, input logic hold_done);
        reset    = 1'b1;
        dut_done = 1'b0;
        dut_fail = 1'b0;
        repeat (n) tick();
        check_val("rst_dut_reset",    32'(dut_reset),    32'd1);
        check_val("rst_running",      32'(running),      32'd0);
        check_val("rst_finish_req",   32'(finish_req),   32'd0);
        check_val("rst_finish_pulse", 32'(finish_pulse), 32'd0);
        check_val("rst_status",       32'(status),       32'd0);
        check_val("rst_cycle_count",  32'(cycle_count),  32'd0);
        reset    = 1'b0;
        dut_done = hold_done;
        for (int i = 0; i < int'(RESET_CYCLES); i++) begin
            check_val("hold_dut_reset", 32'(dut_reset), 32'd1);
            check_val("hold_running",   32'(running),   32'd0);
            tick();
        end
        dut_done = 1'b0;
        check_val("run_dut_reset",   32'(dut_reset),   32'd0);
        check_val("run_running",     32'(running),     32'd1);
        check_val("run_status",      32'(status),      32'd0);
        check_val("run_cycle_count", 32'(cycle_count), 32'd0);
    endtask

    task automatic wait_count(input int target);
        int k = 0;
        while (int'(cycle_count) != target && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check_val("wait_count", 32'(cycle_count), 32'(target));
    endtask

    // Wait for finish_pulse and compare it with the oldest queued expectation.
    task automatic finish_case();
        int   lat = 0;
        exp_t e;
        while (!finish_pulse && lat < 50) begin
            tick();
            lat++;
        end
        check_val("pulse_latency", 32'(lat), 32'(DRAIN_CYCLES));
        if (sb_q.size() == 0) begin
            check_val("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("fin_status",      32'(status),      32'(e.st));
            check_val("fin_cycle_count", 32'(cycle_count), 32'(e.cnt));
        end
        check_val("fin_req", 32'(finish_req), 32'd1);
        tick();
        check_val("fin_pulse_drop", 32'(finish_pulse), 32'd0);
        check_val("fin_req_hold",   32'(finish_req),   32'd1);
    endtask

    // trig < 0 means let the run time out.
    task automatic run_case(input int trig, input logic d, input logic f,
                            input logic [1:0] exp_st, input int exp_cnt);
        exp_t e;
        e.st  = exp_st;
        e.cnt = CNT_W'(exp_cnt);
        if (trig >= 0) begin
            wait_count(trig);
            check_val("pre_running", 32'(running), 32'd1);
            check_val("pre_status",  32'(status),  32'd0);
            dut_done = d;
            dut_fail = f;
            sb_q.push_back(e);
            tick();
            dut_done = 1'b0;
            dut_fail = 1'b0;
        end else begin
            sb_q.push_back(e);
            wait_count(exp_cnt);
        end
        check_val("exit_running",     32'(running),     32'd0);
        check_val("exit_status",      32'(status),      32'(exp_st));
        check_val("exit_cycle_count", 32'(cycle_count), 32'(exp_cnt));
        check_val("exit_no_pulse",    32'(finish_pulse), 32'd0);
        finish_case();
    endtask

    initial begin
        int pc;
        reset    = 1'b1;
        dut_done = 1'b0;
        dut_fail = 1'b0;

        // reset release and pass on cycle 7
        reset_seq(3, 1'b0);
        run_case(7, 1'b1, 1'b0, 2'd1, 8);

        // done after DONE is ignored
        pc       = pulse_cnt;
        dut_done = 1'b1;
        repeat (3) tick();
        dut_done = 1'b0;
        tick();
        check_val("post_status",      32'(status),      32'd1);
        check_val("post_cycle_count", 32'(cycle_count), 32'd8);
        check_val("post_pulses",      32'(pulse_cnt),   32'(pc));
        check_val("post_finish_req",  32'(finish_req),  32'd1);

        // done during HOLD is ignored; then done+fail together is a fail
        reset_seq(3, 1'b1);
        run_case(3, 1'b1, 1'b1, 2'd2, 4);

        // timeout
        reset_seq(3, 1'b0);
        run_case(-1, 1'b0, 1'b0, 2'd3, int'(MAX_CYCLES));

        // reset during DRAIN aborts the run without a finish pulse
        reset_seq(2, 1'b0);
        wait_count(2);
        dut_done = 1'b1;
        tick();
        dut_done = 1'b0;
        check_val("abort_status",      32'(status),      32'd1);
        check_val("abort_cycle_count", 32'(cycle_count), 32'd3);
        tick();
        pc = pulse_cnt;
        reset_seq(1, 1'b0);
        repeat (4) tick();
        check_val("abort_pulses",  32'(pulse_cnt), 32'(pc));
        check_val("abort_req",     32'(finish_req), 32'd0);
        check_val("abort_running", 32'(running),    32'd1);
        check_val("sb_drained",    32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
